// File: rtl/mem_arb_pkg.sv
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and constants for the N-port memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    localparam logic MODE_RR    = 1'b0;
    localparam logic MODE_FIXED = 1'b1;

endpackage

`default_nettype wire

// File: rtl/mem_arb_rr_pick.sv
// ============================================================================
// Module      : rr_pick
// Description : Combinational winner search, rotating from start or from 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick
    import mem_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    input  logic          mode,
    output logic          found,
    output logic [IW-1:0] idx
);

    logic [IW-1:0]  w_base;
    logic [2*N-1:0] w_dbl;
    int             w_pos;

    // Rotate a doubled copy so bit k is the port k steps after the base.
    always_comb begin
        w_base = (mode == MODE_FIXED) ? '0 : start;
        w_dbl  = {req, req} >> w_base;
        found  = 1'b0;
        idx    = '0;
        w_pos  = 0;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_dbl[k]) begin
                found = 1'b1;
                w_pos = int'(w_base) + k;
                if (w_pos >= N) begin
                    w_pos = w_pos - N;
                end
                idx = IW'(w_pos);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_arb_rr.sv
// ============================================================================
// Module      : mem_arb_rr
// Description : N-port round-robin / fixed-priority memory arbiter with
//               locked bursts, optional timeout and abandon handling.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arb_rr
    import mem_arb_pkg::*;
#(
    parameter int N       = 4,
    parameter int AW      = 64,
    parameter int DW      = 64,
    parameter int MODE    = 0,
    parameter int TIMEOUT = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    req_a,
    input  logic [N-1:0]    wr_a,
    input  logic [N-1:0]    lock_a,
    input  logic [N*AW-1:0] addr_a,
    input  logic [N*DW-1:0] dout_a,
    output logic [N*DW-1:0] din_a,
    output logic [N-1:0]    rdy_a,
    output logic [N-1:0]    err_a,
    output logic [AW-1:0]   addr_m,
    output logic [DW-1:0]   dout_m,
    input  logic [DW-1:0]   din_m,
    output logic            req_m,
    output logic            wr_m,
    input  logic            rdy_m,
    output logic [N-1:0]    grant,
    output logic            busy
);

    localparam int IW = $clog2(N);
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    state_e        state_q, state_d;
    logic [IW-1:0] cur_q, cur_d;
    logic [IW-1:0] last_q, last_d;
    logic [TW-1:0] tcnt_q, tcnt_d;

    logic [AW-1:0] w_addr [N];
    logic [DW-1:0] w_dout [N];
    logic          w_busy, w_alive, w_beat, w_tout, w_found, w_mode;
    logic [IW-1:0] w_start, w_idx;

    assign w_busy  = (state_q == BUSY);
    assign w_alive = w_busy && req_a[cur_q];
    assign w_beat  = w_alive && rdy_m;
    // A completing beat or an abandon in the last allowed cycle beats the timeout.
    assign w_tout  = (TIMEOUT > 0) && w_alive && !rdy_m && (tcnt_q == TW'(TIMEOUT - 1));
    assign w_mode  = (MODE != 0) ? MODE_FIXED : MODE_RR;
    assign w_start = (last_q == IW'(N - 1)) ? '0 : last_q + IW'(1);

    generate
        for (genvar i = 0; i < N; i++) begin : g_port
            assign w_addr[i]             = addr_a[AW*i +: AW];
            assign w_dout[i]             = dout_a[DW*i +: DW];
            assign grant[i]              = w_busy && (cur_q == IW'(i));
            assign rdy_a[i]              = w_beat && grant[i];
            assign err_a[i]              = w_tout && grant[i];
            assign din_a[DW*i +: DW]     = rdy_a[i] ? din_m : '0;
        end
    endgenerate

    assign busy   = w_busy;
    assign req_m  = w_alive && !w_tout;
    assign wr_m   = w_busy && wr_a[cur_q];
    assign addr_m = w_busy ? w_addr[cur_q] : '0;
    assign dout_m = w_busy ? w_dout[cur_q] : '0;

    rr_pick #(
        .N (N)
    ) u_pick (
        .req   (req_a),
        .start (w_start),
        .mode  (w_mode),
        .found (w_found),
        .idx   (w_idx)
    );

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        last_d  = last_q;
        tcnt_d  = tcnt_q;
        case (state_q)
            IDLE: begin
                if (w_found) begin
                    state_d = BUSY;
                    cur_d   = w_idx;
                    tcnt_d  = '0;
                end
            end
            BUSY: begin
                if (!req_a[cur_q]) begin
                    state_d = IDLE;
                    last_d  = cur_q;
                end else if (rdy_m) begin
                    if (lock_a[cur_q]) begin
                        tcnt_d = '0;
                    end else begin
                        state_d = IDLE;
                        last_d  = cur_q;
                    end
                end else if (w_tout) begin
                    state_d = IDLE;
                    last_d  = cur_q;
                end else if (TIMEOUT > 0) begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cur_q   <= '0;
            last_q  <= IW'(N - 1);
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            last_q  <= last_d;
            tcnt_q  <= tcnt_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_arb_rr.sv
// ============================================================================
// Module      : tb_mem_arb_rr
// Description : Three arbiter configurations driven from shared stimulus and
//               compared cycle by cycle against a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arb_rr;

    localparam int AW   = 16;
    localparam int DW   = 16;
    localparam int NMAX = 5;
    localparam int NP [3] = '{4, 5, 3};
    localparam int MD [3] = '{0, 1, 0};
    localparam int TO [3] = '{8, 0, 0};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 reset;
    logic [NMAX-1:0]      req_a, wr_a, lock_a;
    logic [NMAX*AW-1:0]   addr_a;
    logic [NMAX*DW-1:0]   dout_a;
    logic [DW-1:0]        din_m;
    logic                 rdy_m;

    logic                 s_reset;
    logic [NMAX-1:0]      s_req, s_wr, s_lock;
    logic [NMAX*AW-1:0]   s_addr;
    logic [NMAX*DW-1:0]   s_dout;
    logic [DW-1:0]        s_din;
    logic                 s_rdy;

    logic [4*DW-1:0] a_din;  logic [3:0] a_rdy, a_err, a_grant;
    logic [5*DW-1:0] b_din;  logic [4:0] b_rdy, b_err, b_grant;
    logic [3*DW-1:0] c_din;  logic [2:0] c_rdy, c_err, c_grant;
    logic [AW-1:0]   a_addr, b_addr, c_addr;
    logic [DW-1:0]   a_dout, b_dout, c_dout;
    logic            a_req, a_wr, a_busy, b_req, b_wr, b_busy, c_req, c_wr, c_busy;

    mem_arb_rr #(.N(4), .AW(AW), .DW(DW), .MODE(0), .TIMEOUT(8)) u_a (
        .clk(clk), .reset(reset), .req_a(req_a[3:0]), .wr_a(wr_a[3:0]), .lock_a(lock_a[3:0]),
        .addr_a(addr_a[4*AW-1:0]), .dout_a(dout_a[4*DW-1:0]), .din_a(a_din), .rdy_a(a_rdy),
        .err_a(a_err), .addr_m(a_addr), .dout_m(a_dout), .din_m(din_m), .req_m(a_req),
        .wr_m(a_wr), .rdy_m(rdy_m), .grant(a_grant), .busy(a_busy));

    mem_arb_rr #(.N(5), .AW(AW), .DW(DW), .MODE(1), .TIMEOUT(0)) u_b (
        .clk(clk), .reset(reset), .req_a(req_a), .wr_a(wr_a), .lock_a(lock_a),
        .addr_a(addr_a), .dout_a(dout_a), .din_a(b_din), .rdy_a(b_rdy),
        .err_a(b_err), .addr_m(b_addr), .dout_m(b_dout), .din_m(din_m), .req_m(b_req),
        .wr_m(b_wr), .rdy_m(rdy_m), .grant(b_grant), .busy(b_busy));

    mem_arb_rr #(.N(3), .AW(AW), .DW(DW), .MODE(0), .TIMEOUT(0)) u_c (
        .clk(clk), .reset(reset), .req_a(req_a[2:0]), .wr_a(wr_a[2:0]), .lock_a(lock_a[2:0]),
        .addr_a(addr_a[3*AW-1:0]), .dout_a(dout_a[3*DW-1:0]), .din_a(c_din), .rdy_a(c_rdy),
        .err_a(c_err), .addr_m(c_addr), .dout_m(c_dout), .din_m(din_m), .req_m(c_req),
        .wr_m(c_wr), .rdy_m(rdy_m), .grant(c_grant), .busy(c_busy));

    // Per-instance views padded to the widest configuration.
    logic [NMAX-1:0]    o_grant [3], o_rdy [3], o_err [3];
    logic [NMAX*DW-1:0] o_din [3];
    logic [AW-1:0]      o_addr [3];
    logic [DW-1:0]      o_dout [3];
    logic               o_req [3], o_wr [3], o_busy [3];

    always_comb begin
        for (int m = 0; m < 3; m++) begin
            o_grant[m] = '0; o_rdy[m] = '0; o_err[m] = '0; o_din[m] = '0;
        end
        o_grant[0][3:0] = a_grant; o_rdy[0][3:0] = a_rdy; o_err[0][3:0] = a_err; o_din[0][4*DW-1:0] = a_din;
        o_grant[1]      = b_grant; o_rdy[1]      = b_rdy; o_err[1]      = b_err; o_din[1]           = b_din;
        o_grant[2][2:0] = c_grant; o_rdy[2][2:0] = c_rdy; o_err[2][2:0] = c_err; o_din[2][3*DW-1:0] = c_din;
        o_addr[0] = a_addr; o_addr[1] = b_addr; o_addr[2] = c_addr;
        o_dout[0] = a_dout; o_dout[1] = b_dout; o_dout[2] = c_dout;
        o_req[0]  = a_req;  o_req[1]  = b_req;  o_req[2]  = c_req;
        o_wr[0]   = a_wr;   o_wr[1]   = b_wr;   o_wr[2]   = c_wr;
        o_busy[0] = a_busy; o_busy[1] = b_busy; o_busy[2] = c_busy;
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Model state: owner port (-1 = nobody), last served port, cycles waited.
    int own [3], lst [3], tc [3];

    task automatic model_check(input int m);
        int n, p;
        logic [2:0] ci;
        logic alive, tout, hit;
        logic [NMAX-1:0] eg, er, ee;
        logic [NMAX*DW-1:0] ed;
        logic erq, ewr, eb;
        logic [AW-1:0] ea;
        logic [DW-1:0] edo;
        n = NP[m];
        eg = '0; er = '0; ee = '0; ed = '0; erq = 0; ewr = 0; eb = 0; ea = '0; edo = '0;
        alive = 0; tout = 0; ci = '0;
        if (own[m] >= 0) begin
            ci    = 3'(own[m]);
            alive = req_a[ci];
            tout  = (TO[m] > 0) && (tc[m] == TO[m] - 1) && !rdy_m && alive;
            eb    = 1;
            eg[ci] = 1'b1;
            erq   = alive && !tout;
            ewr   = wr_a[ci];
            ea    = addr_a[AW*own[m] +: AW];
            edo   = dout_a[DW*own[m] +: DW];
            if (alive && rdy_m) begin
                er[ci] = 1'b1;
                ed[DW*own[m] +: DW] = din_m;
            end
            if (tout) ee[ci] = 1'b1;
        end
        check($sformatf("u%0d.grant", m), o_grant[m], eg);
        check($sformatf("u%0d.busy", m),  o_busy[m],  eb);
        check($sformatf("u%0d.req_m", m), o_req[m],   erq);
        check($sformatf("u%0d.wr_m", m),  o_wr[m],    ewr);
        check($sformatf("u%0d.addr_m", m), o_addr[m], ea);
        check($sformatf("u%0d.dout_m", m), o_dout[m], edo);
        check($sformatf("u%0d.rdy_a", m), o_rdy[m],   er);
        check($sformatf("u%0d.err_a", m), o_err[m],   ee);
        check($sformatf("u%0d.din_a", m), o_din[m],   ed);

        if (reset) begin
            own[m] = -1; lst[m] = n - 1; tc[m] = 0;
        end else if (own[m] < 0) begin
            hit = 0;
            for (int k = 1; k <= n; k++) begin
                p = (MD[m] != 0) ? k - 1 : (lst[m] + k) % n;
                if (!hit && req_a[3'(p)]) begin
                    hit = 1; own[m] = p; tc[m] = 0;
                end
            end
        end else if (!alive) begin
            lst[m] = own[m]; own[m] = -1;
        end else if (rdy_m) begin
            if (lock_a[ci]) tc[m] = 0;
            else begin lst[m] = own[m]; own[m] = -1; end
        end else if (tout) begin
            lst[m] = own[m]; own[m] = -1;
        end else begin
            tc[m] = tc[m] + 1;
        end
    endtask

    bit rec = 0;
    bit prev_busy0 = 0;
    int order [$];

    task automatic cycle();
        @(negedge clk);
        reset = s_reset; req_a = s_req; wr_a = s_wr; lock_a = s_lock;
        addr_a = s_addr; dout_a = s_dout; din_m = s_din; rdy_m = s_rdy;
        #2;
        if (rec && o_busy[0] && !prev_busy0) begin
            for (int i = 0; i < 4; i++) if (o_grant[0][i]) order.push_back(i);
        end
        prev_busy0 = o_busy[0];
        for (int m = 0; m < 3; m++) model_check(m);
    endtask

    task automatic randomize_data();
        s_wr = NMAX'($urandom);
        for (int i = 0; i < NMAX; i++) begin
            s_addr[AW*i +: AW] = AW'($urandom);
            s_dout[DW*i +: DW] = DW'($urandom);
        end
    endtask

    int pct;
    int exp_order [5] = '{0, 1, 2, 3, 0};

    initial begin
        s_reset = 1; s_req = '0; s_wr = '0; s_lock = '0; s_addr = '0; s_dout = '0;
        s_din = '0; s_rdy = 0;
        reset = 1; req_a = '0; wr_a = '0; lock_a = '0; addr_a = '0; dout_a = '0;
        din_m = '0; rdy_m = 0;
        repeat (2) @(posedge clk);
        for (int m = 0; m < 3; m++) begin own[m] = -1; lst[m] = NP[m] - 1; tc[m] = 0; end
        repeat (2) cycle();
        s_reset = 0;
        randomize_data();

        // All ports requesting, every beat completes immediately.
        s_req = 5'b01111; s_rdy = 1; s_din = 16'h00A5; rec = 1;
        repeat (14) cycle();
        rec = 0;
        check("a.order_len", order.size() >= 5, 1'b1);
        for (int i = 0; i < 5; i++) if (i < order.size()) check($sformatf("a.order%0d", i), order[i], exp_order[i]);

        // Locked burst on port 2 with port 0 competing.
        s_req = 5'b00000; s_rdy = 0; repeat (2) cycle();
        s_req = 5'b00101; s_lock = 5'b00100; s_rdy = 0; s_din = 16'h1234;
        repeat (2) cycle();
        s_rdy = 1; repeat (2) cycle();
        s_lock = 5'b00000; repeat (6) cycle();

        // Timeout on port 1, then port 0 joins.
        s_req = 5'b00000; s_rdy = 0; repeat (2) cycle();
        s_req = 5'b00010; repeat (11) cycle();
        s_req = 5'b00011; repeat (4) cycle();

        // Port 3 abandons in the same cycle rdy_m arrives.
        s_req = 5'b00000; repeat (2) cycle();
        s_req = 5'b01000; randomize_data(); repeat (3) cycle();
        s_req = 5'b00000; s_rdy = 1; repeat (3) cycle();

        // Ports 1 and 3 both requesting.
        s_req = 5'b01010; s_rdy = 1; repeat (10) cycle();

        // Reset in mid-transaction.
        s_req = 5'b00111; s_rdy = 0; repeat (3) cycle();
        s_reset = 1; cycle();
        s_reset = 0; repeat (5) cycle();

        pct = 50;
        for (int t = 0; t < 3000; t++) begin
            if (t % 250 == 0) pct = (t / 250) % 3 == 0 ? 5 : ((t / 250) % 3 == 1 ? 50 : 95);
            for (int i = 0; i < NMAX; i++) begin
                if (!s_req[i]) s_req[i] = ($urandom_range(3) == 0);
                else if ($urandom_range(15) == 0) s_req[i] = 1'b0;
                s_lock[i] = ($urandom_range(3) == 0);
            end
            randomize_data();
            s_din   = DW'($urandom);
            s_rdy   = ($urandom_range(99) < pct);
            s_reset = ($urandom_range(499) == 0);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
